// File: rtl/wb_bridge_host_sequencer_if.sv
// Request/response port and 8-bit bridge pin group for the host sequencer.
// req: a request transfers on the cycle req_valid && req_ready are both high; rsp_valid is a one-cycle pulse with no back-pressure.
interface wb_bridge_host_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [13:0] req_adr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [2:0]  bridge_cmd;
    logic [7:0]  bridge_dat;
    logic [7:0]  bridge_rdat;
    logic        bridge_valid;
    logic [3:0]  dbg_state;

    modport master (
        input  req_valid, req_we, req_adr, req_wdata, bridge_rdat, bridge_valid,
        output req_ready, rsp_valid, rsp_err, rsp_rdata, bridge_cmd, bridge_dat, dbg_state
    );

    modport slave (
        output req_valid, req_we, req_adr, req_wdata, bridge_rdat, bridge_valid,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata, bridge_cmd, bridge_dat, dbg_state
    );
endinterface

// File: rtl/wb_bridge_host_sequencer.sv
// Host-side sequencer: turns one 32-bit request into the AD/DO/EXEC/DI byte stream
// of the pin-level wishbone bridge and assembles the read response.
module wb_bridge_host_sequencer #(
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 16
) (
    input logic clk,
    input logic reset,
    wb_bridge_host_sequencer_if.master bus
);
    localparam logic [2:0] C_IDLE = 3'd0;
    localparam logic [2:0] C_EXEC = 3'd1;
    localparam logic [2:0] C_AD0  = 3'd2;
    localparam logic [2:0] C_DO0  = 3'd4;
    localparam logic [2:0] C_DI0  = 3'd6;

    localparam logic [7:0] OP_RESET   = 8'h01;
    localparam logic [7:0] OP_DISABLE = 8'h04;
    localparam logic [7:0] OP_ENABLE  = 8'h05;
    localparam logic [7:0] OP_READ    = 8'h06;
    localparam logic [7:0] OP_WRITE   = 8'h07;

    typedef enum logic [3:0] {
        S_BOOT, S_IDLE, S_ADL, S_ADH, S_DO_0, S_DO_1, S_DO_2, S_DO_3,
        S_ENA, S_GO, S_RD1, S_RD2, S_RD3, S_DIS, S_RSP
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_we;
    logic [13:0]     r_adr;
    logic [31:0]     r_wdata;
    logic [23:0]     r_rd;
    logic            r_err;
    logic [TO_W-1:0] r_to_cnt;
    logic [2:0]      r_cmd;
    logic [7:0]      r_dat;
    logic            r_req_ready;
    logic            r_rsp_valid;
    logic [31:0]     r_rsp_rdata;

    logic [2:0]      w_cmd_nxt;
    logic [7:0]      w_dat_nxt;
    logic [31:0]     w_rdata_nxt;
    logic            w_accept;
    logic            w_to_hit;
    logic [13:0]     w_adr;

    assign w_accept = r_req_ready && bus.req_valid;
    assign w_to_hit = (TIMEOUT != 0) && (r_to_cnt == TO_W'(TIMEOUT - 1));
    // The low address byte goes out on the cycle after acceptance, before r_adr is visible.
    assign w_adr    = w_accept ? bus.req_adr : r_adr;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_BOOT;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT: w_state_nxt = S_IDLE;
            S_IDLE: if (w_accept) w_state_nxt = S_ADL;
            S_ADL:  w_state_nxt = S_ADH;
            S_ADH:  w_state_nxt = r_we ? S_DO_0 : S_ENA;
            S_DO_0: w_state_nxt = S_DO_1;
            S_DO_1: w_state_nxt = S_DO_2;
            S_DO_2: w_state_nxt = S_DO_3;
            S_DO_3: w_state_nxt = S_ENA;
            S_ENA:  w_state_nxt = S_GO;
            S_GO: begin
                if (bus.bridge_valid) w_state_nxt = r_we ? S_DIS : S_RD1;
                else if (w_to_hit)    w_state_nxt = S_DIS;
            end
            S_RD1:  w_state_nxt = S_RD2;
            S_RD2:  w_state_nxt = S_RD3;
            S_RD3:  w_state_nxt = S_DIS;
            S_DIS:  w_state_nxt = S_RSP;
            S_RSP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    // Pin values are decoded from the next state so the registered outputs line up with the state.
    always_comb begin
        w_cmd_nxt = C_IDLE;
        w_dat_nxt = 8'h00;
        case (w_state_nxt)
            S_BOOT: begin w_cmd_nxt = C_EXEC; w_dat_nxt = OP_RESET; end
            S_ADL:  begin w_cmd_nxt = C_AD0;  w_dat_nxt = w_adr[7:0]; end
            S_ADH:  begin w_cmd_nxt = C_AD0;  w_dat_nxt = {2'b00, r_adr[13:8]}; end
            S_DO_0: begin w_cmd_nxt = C_DO0;  w_dat_nxt = r_wdata[7:0]; end
            S_DO_1: begin w_cmd_nxt = C_DO0;  w_dat_nxt = r_wdata[15:8]; end
            S_DO_2: begin w_cmd_nxt = C_DO0;  w_dat_nxt = r_wdata[23:16]; end
            S_DO_3: begin w_cmd_nxt = C_DO0;  w_dat_nxt = r_wdata[31:24]; end
            S_ENA:  begin w_cmd_nxt = C_EXEC; w_dat_nxt = OP_ENABLE; end
            S_GO:   begin w_cmd_nxt = C_EXEC; w_dat_nxt = r_we ? OP_WRITE : OP_READ; end
            S_RD1, S_RD2, S_RD3: w_cmd_nxt = C_DI0;
            S_DIS:  begin w_cmd_nxt = C_EXEC; w_dat_nxt = OP_DISABLE; end
            default: ;
        endcase
    end

    // Byte 3 is on bridge_rdat during DIS, which is the only state leading into RSP.
    assign w_rdata_nxt = (w_state_nxt == S_RSP && !r_we && !r_err) ? {bus.bridge_rdat, r_rd} : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd       <= C_EXEC;
            r_dat       <= OP_RESET;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_err       <= 1'b0;
            r_to_cnt    <= '0;
            r_we        <= 1'b0;
            r_adr       <= 14'h0;
            r_wdata     <= 32'h0;
            r_rd        <= 24'h0;
        end else begin
            r_cmd       <= w_cmd_nxt;
            r_dat       <= w_dat_nxt;
            r_req_ready <= (w_state_nxt == S_IDLE);
            r_rsp_valid <= (w_state_nxt == S_RSP);
            r_rsp_rdata <= w_rdata_nxt;
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_adr   <= bus.req_adr;
                r_wdata <= bus.req_wdata;
                r_err   <= 1'b0;
            end
            if (r_state == S_ENA)     r_to_cnt <= '0;
            else if (r_state == S_GO) r_to_cnt <= r_to_cnt + TO_W'(1);
            if (r_state == S_GO && !bus.bridge_valid && w_to_hit) r_err <= 1'b1;
            case (r_state)
                S_RD1:   r_rd[7:0]   <= bus.bridge_rdat;
                S_RD2:   r_rd[15:8]  <= bus.bridge_rdat;
                S_RD3:   r_rd[23:16] <= bus.bridge_rdat;
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_err    = r_err;
    assign bus.rsp_rdata  = r_rsp_rdata;
    assign bus.bridge_cmd = r_cmd;
    assign bus.bridge_dat = r_dat;
    assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_wb_bridge_host_sequencer.sv
// Bench for wb_bridge_host_sequencer: pin-level bridge/slave model, transaction-level
// reference memory, and scoreboards for the byte stream and the responses.
module tb_wb_bridge_host_sequencer;
    localparam int TIMEOUT = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wb_bridge_host_sequencer_if bus ();

    wb_bridge_host_sequencer #(.TIMEOUT(TIMEOUT), .TO_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    int unsigned accept_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        we;
        logic [13:0] adr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        logic [15:0] lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [10:0] exp_stream_q[$];

    // Power-up contents of the slave memory behind the bridge.
    function automatic logic [31:0] init_word(input logic [13:0] a);
        if (a == 14'h0010) return 32'h1234_5678;
        return {2'b01, a, 2'b10, ~a};
    endfunction

    // ---------------- reference memory (transaction level) ----------------
    bit          ref_wr  [0:16383];
    logic [31:0] ref_dat [0:16383];

    function automatic logic [31:0] ref_read(input logic [13:0] a);
        return ref_wr[a] ? ref_dat[a] : init_word(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // ---------------- pin-level bridge + slave model ----------------
    logic [15:0] m_adr   = 16'h0;
    logic [31:0] m_do    = 32'h0;
    logic        m_valid = 1'b0;
    int          m_go    = 0;
    logic [31:0] m_rd    = 32'h0;
    logic [1:0]  m_idx   = 2'd0;
    int          cfg_waits = 0;
    bit          cfg_noack = 1'b0;
    bit          slave_wr  [0:16383];
    logic [31:0] slave_dat [0:16383];
    logic [31:0] m_sh;

    assign m_sh             = m_rd >> {m_idx, 3'b000};
    assign bus.bridge_rdat  = m_sh[7:0];
    assign bus.bridge_valid = m_valid;

    always @(posedge clk) begin
        case (bus.bridge_cmd)
            3'd1: begin
                case (bus.bridge_dat)
                    8'h01: begin
                        m_valid <= 1'b0; m_adr <= 16'h0; m_do <= 32'h0; m_go <= 0; m_idx <= 2'd0;
                    end
                    8'h05: begin m_valid <= 1'b0; m_go <= 0; end
                    8'h06, 8'h07: begin
                        m_go <= m_go + 1;
                        if (!m_valid && !cfg_noack && (m_go + 1 >= 2 + cfg_waits)) begin
                            m_valid <= 1'b1;
                            if (bus.bridge_dat == 8'h07) begin
                                slave_wr[m_adr[13:0]]  <= 1'b1;
                                slave_dat[m_adr[13:0]] <= m_do;
                            end else begin
                                m_rd  <= slave_wr[m_adr[13:0]] ? slave_dat[m_adr[13:0]] : init_word(m_adr[13:0]);
                                m_idx <= 2'd0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            3'd2: m_adr <= {bus.bridge_dat, m_adr[15:8]};
            3'd4: m_do  <= {bus.bridge_dat, m_do[31:8]};
            3'd6: m_idx <= m_idx + 2'd1;
            default: ;
        endcase
    end

    // ---------------- monitors / scoreboard ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.req_valid && bus.req_ready) accept_cyc = cyc;
            if (bus.req_ready) check("ready_only_idle", {28'h0, bus.bridge_cmd, bus.rsp_valid}, 32'h0);
            if (bus.bridge_cmd == 3'd0) begin
                check("idle_dat", {24'h0, bus.bridge_dat}, 32'h0);
            end else if (!(bus.bridge_cmd == 3'd1 && bus.bridge_dat == 8'h01)) begin
                if (exp_stream_q.size() == 0) begin
                    $display("FAIL stream_extra: got cmd %0d dat %h with nothing expected", bus.bridge_cmd, bus.bridge_dat);
                    checks++; errors++;
                end else begin
                    logic [10:0] es;
                    es = exp_stream_q.pop_front();
                    check("stream", {21'h0, bus.bridge_cmd, bus.bridge_dat}, {21'h0, es});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
                fail("rsp_unexpected");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_err", {31'h0, bus.rsp_err}, {31'h0, e.err});
                check("rsp_rdata", bus.rsp_rdata, e.rdata);
                check("rsp_latency", cyc - accept_cyc, {16'h0, e.lat});
                if (e.we && !e.err) begin
                    ref_wr[e.adr]  = 1'b1;
                    ref_dat[e.adr] = e.wdata;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input bit we, input logic [13:0] adr, input logic [31:0] wdata,
                         input int waits, input bit noack);
        exp_t e;
        int   go;
        bit   acc;
        logic [7:0] b;
        acc = 1'b0;
        @(posedge clk); #1;
        bus.req_we    = we;
        bus.req_adr   = adr;
        bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin acc = 1'b1; break; end
        end
        if (!acc) begin
            fail("accept_timeout");
            return;
        end
        go      = noack ? TIMEOUT : 3 + waits;
        e.we    = we;
        e.adr   = adr;
        e.wdata = wdata;
        e.err   = noack;
        e.rdata = (we || noack) ? 32'h0 : ref_read(adr);
        e.lat   = 16'(we ? 9 + go : (noack ? 5 + go : 8 + go));
        exp_q.push_back(e);
        exp_stream_q.push_back({3'd2, adr[7:0]});
        exp_stream_q.push_back({3'd2, 2'b00, adr[13:8]});
        if (we) begin
            for (int k = 0; k < 4; k++) begin
                b = wdata[8*k +: 8];
                exp_stream_q.push_back({3'd4, b});
            end
        end
        exp_stream_q.push_back({3'd1, 8'h05});
        for (int k = 0; k < go; k++) exp_stream_q.push_back({3'd1, we ? 8'h07 : 8'h06});
        if (!we && !noack) for (int k = 0; k < 3; k++) exp_stream_q.push_back({3'd6, 8'h00});
        exp_stream_q.push_back({3'd1, 8'h04});
        @(posedge clk); #1;
        cfg_waits = waits;
        cfg_noack = noack;
    endtask

    task automatic drop();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin done = 1'b1; break; end
        end
        if (!done) begin
            fail("rsp_wait_timeout");
            exp_q.delete();
            exp_stream_q.delete();
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        bus.req_valid = 1'b0;
        exp_q.delete();
        exp_stream_q.delete();
        repeat (n) @(posedge clk);
        @(negedge clk);
        check("rst_cmd", {21'h0, bus.bridge_cmd, bus.bridge_dat}, {21'h0, 3'd1, 8'h01});
        check("rst_ready", {31'h0, bus.req_ready}, 32'h0);
        check("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        check("rst_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("boot_cmd", {21'h0, bus.bridge_cmd, bus.bridge_dat}, {21'h0, 3'd1, 8'h01});
        check("boot_ready", {31'h0, bus.req_ready}, 32'h0);
        @(negedge clk);
        check("idle_cmd", {29'h0, bus.bridge_cmd}, 32'h0);
        check("idle_ready", {31'h0, bus.req_ready}, 32'h1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [13:0] a;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_adr   = 14'h0;
        bus.req_wdata = 32'h0;

        do_reset(3);

        issue(1'b1, 14'h2A5C, 32'hDEAD_BEEF, 0, 1'b0); drop(); wait_done();
        check("model_adr", {16'h0, m_adr}, 32'h0000_2A5C);
        check("model_do", m_do, 32'hDEAD_BEEF);

        issue(1'b0, 14'h0010, 32'h0, 2, 1'b0); drop(); wait_done();
        issue(1'b0, 14'h2A5C, 32'h0, 0, 1'b0); drop(); wait_done();

        issue(1'b0, 14'h0100, 32'h0, 0, 1'b1); drop(); wait_done();
        issue(1'b0, 14'h0100, 32'h0, 1, 1'b0); drop(); wait_done();

        issue(1'b1, 14'h0333, 32'h0BAD_F00D, 1, 1'b0);
        issue(1'b0, 14'h0333, 32'h0, 0, 1'b0); drop(); wait_done();

        issue(1'b1, 14'h1234, 32'hCAFE_F00D, 0, 1'b0); drop();
        repeat (5) @(negedge clk);
        check("mid_do2", {21'h0, bus.bridge_cmd, bus.bridge_dat}, {21'h0, 3'd4, 8'hFE});
        #1;
        do_reset(2);
        issue(1'b0, 14'h1234, 32'h0, 0, 1'b0); drop(); wait_done();

        for (int t = 0; t < 24; t++) begin
            case ($urandom_range(0, 3))
                0:       a = 14'h0010;
                1:       a = 14'h2A5C;
                2:       a = 14'h0333;
                default: a = 14'($urandom_range(0, 16383));
            endcase
            issue(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 4), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 1) == 1) drop();
        end
        drop();
        wait_done();

        repeat (4) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 32'h0);
        check("stream_q_empty", exp_stream_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
